fir_mac_accumulator: RTL and testbench

Multiply-accumulate back end of the polyphase FIR lowpass decimator, directly downstream of the sample/coefficient memory controller. Per output sample, it multiplies MAC_NUM lanes of samples from two polyphase banks by the shared coefficient stream over MAC_SIZE taps. It sums the lanes and the active banks, then rounds, saturates and emits one decimated sample with a single-cycle valid strobe.

---
 rtl/fir_mac_accumulator.sv | 191 +++++++++++++++++++
 tb/tb_fir_mac_accumulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_accumulator.sv
// Polyphase FIR decimator MAC back end: two-bank, multi-lane multiply-accumulate
// with round-half-up, arithmetic shift and saturation to one output per pass.
module fir_mac_accumulator #(
  parameter int unsigned MAC_SIZE    = 255,
  parameter int unsigned MAC_NUM     = 1,
  parameter int unsigned SAMPLE_SIZE = 16,
  parameter int unsigned COEFF_SIZE  = 16,
  parameter int unsigned OUT_SIZE    = 16,
  parameter int unsigned SHIFT       = COEFF_SIZE - 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic                           en_0_i,
  input  logic                           en_1_i,
  input  logic [SAMPLE_SIZE*MAC_NUM-1:0] s_in_0_i,
  input  logic [SAMPLE_SIZE*MAC_NUM-1:0] s_in_1_i,
  input  logic [COEFF_SIZE*MAC_NUM-1:0]  c_in_i,
  output logic [OUT_SIZE-1:0]            y_out_o,
  output logic                           y_valid_o,
  output logic                           busy_o,
  output logic                           overrun_o
);

  localparam int unsigned PROD_W = SAMPLE_SIZE + COEFF_SIZE;
  localparam int unsigned LANE_W = PROD_W + 1 + $clog2(MAC_NUM);
  localparam int unsigned ACC_W  = LANE_W + $clog2(MAC_SIZE);
  localparam int unsigned TAP_W  = (MAC_SIZE > 1) ? $clog2(MAC_SIZE) : 1;
  localparam int unsigned RND_W  = ACC_W + 1;

  localparam logic [TAP_W-1:0]        TAP_LAST = TAP_W'(MAC_SIZE - 1);
  localparam logic signed [RND_W-1:0] RND      = RND_W'(1) << (SHIFT - 1);
  localparam logic signed [RND_W-1:0] OMAX     = RND_W'((64'sd1 <<< (OUT_SIZE - 1)) - 64'sd1);
  localparam logic signed [RND_W-1:0] OMIN     = ~OMAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAPS  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [TAP_W-1:0]  tap_q, tap_d;
  logic [1:0]        mask_q, mask_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              accept, abort;

  logic              v1_q, v1_d, first1_q, first1_d, last1_q, last1_d;
  logic              v2_q, v2_d, first2_q, first2_d, last2_q, last2_d;
  logic              acc_last_q, acc_last_d;
  logic              y_valid_q, y_valid_d;

  logic signed [PROD_W-1:0] p0_q [MAC_NUM];
  logic signed [PROD_W-1:0] p1_q [MAC_NUM];
  logic signed [PROD_W-1:0] p0_d [MAC_NUM];
  logic signed [PROD_W-1:0] p1_d [MAC_NUM];
  logic signed [LANE_W-1:0] lane_q, lane_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [RND_W-1:0]  rounded, shifted;
  logic [OUT_SIZE-1:0]      y_q, y_d;

  // Control: start acceptance, tap sequencing, abort-on-restart and pipeline tags
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    mask_d     = mask_q;
    accept     = start_i && (en_0_i || en_1_i);
    abort      = accept && (state_q != IDLE);
    overrun_d  = overrun_q || (abort && !y_valid_q);

    case (state_q)
      IDLE: begin
        if (accept) state_d = TAPS;
      end
      TAPS: begin
        if (tap_q == TAP_LAST) state_d = DRAIN;
        else                   tap_d   = TAP_W'(tap_q + 1'b1);
      end
      DRAIN: begin
        if (y_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = TAPS;
      tap_d   = '0;
      mask_d  = {en_1_i, en_0_i};
    end

    busy_d     = (state_d != IDLE);
    v1_d       = (state_q == TAPS) && !abort;
    first1_d   = (tap_q == '0);
    last1_d    = (tap_q == TAP_LAST);
    v2_d       = v1_q && !abort;
    first2_d   = first1_q;
    last2_d    = last1_q;
    acc_last_d = v2_q && last2_q && !abort;
    y_valid_d  = acc_last_q && !abort;
  end

  // P1..P4 datapath
  always_comb begin
    for (int unsigned k = 0; k < MAC_NUM; k++) begin
      p0_d[k] = mask_q[0]
              ? PROD_W'($signed(s_in_0_i[k*SAMPLE_SIZE +: SAMPLE_SIZE]))
                * PROD_W'($signed(c_in_i[k*COEFF_SIZE +: COEFF_SIZE]))
              : '0;
      p1_d[k] = mask_q[1]
              ? PROD_W'($signed(s_in_1_i[k*SAMPLE_SIZE +: SAMPLE_SIZE]))
                * PROD_W'($signed(c_in_i[k*COEFF_SIZE +: COEFF_SIZE]))
              : '0;
    end

    lane_d = '0;
    for (int unsigned k = 0; k < MAC_NUM; k++) begin
      lane_d = lane_d + LANE_W'(p0_q[k]) + LANE_W'(p1_q[k]);
    end

    acc_d = acc_q;
    if (v2_q) acc_d = first2_q ? ACC_W'(lane_q) : acc_q + ACC_W'(lane_q);

    rounded = RND_W'(acc_q) + RND;
    shifted = rounded >>> SHIFT;
    y_d     = y_q;
    if (y_valid_d) begin
      if (shifted > OMAX)      y_d = OUT_SIZE'(OMAX);
      else if (shifted < OMIN) y_d = OUT_SIZE'(OMIN);
      else                     y_d = OUT_SIZE'(shifted);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tap_q      <= '0;
      mask_q     <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      v1_q       <= 1'b0;
      first1_q   <= 1'b0;
      last1_q    <= 1'b0;
      v2_q       <= 1'b0;
      first2_q   <= 1'b0;
      last2_q    <= 1'b0;
      acc_last_q <= 1'b0;
      y_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      mask_q     <= mask_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      v1_q       <= v1_d;
      first1_q   <= first1_d;
      last1_q    <= last1_d;
      v2_q       <= v2_d;
      first2_q   <= first2_d;
      last2_q    <= last2_d;
      acc_last_q <= acc_last_d;
      y_valid_q  <= y_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < MAC_NUM; k++) begin
        p0_q[k] <= '0;
        p1_q[k] <= '0;
      end
      lane_q <= '0;
      acc_q  <= '0;
      y_q    <= '0;
    end else begin
      for (int unsigned k = 0; k < MAC_NUM; k++) begin
        p0_q[k] <= p0_d[k];
        p1_q[k] <= p1_d[k];
      end
      lane_q <= lane_d;
      acc_q  <= acc_d;
      y_q    <= y_d;
    end
  end

  assign y_out_o   = y_q;
  assign y_valid_o = y_valid_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fir_mac_accumulator.sv
// Directed-vector bench for fir_mac_accumulator (8 taps, 2 lanes, Q15 scaling).
module tb_fir_mac_accumulator;

  localparam int unsigned MS = 8;
  localparam int unsigned MN = 2;
  localparam int unsigned SS = 16;
  localparam int unsigned CS = 16;
  localparam int unsigned OS = 16;

  typedef struct {
    logic        en0;
    logic        en1;
    logic [31:0] s0_first;
    logic [31:0] s0_rest;
    logic [31:0] s1;
    logic [31:0] c;
    logic [15:0] exp_y;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                en_0, en_1;
  logic [SS*MN-1:0]    s_in_0, s_in_1;
  logic [CS*MN-1:0]    c_in;
  logic [OS-1:0]       y_out;
  logic                y_valid, busy, overrun;

  int                  cyc = 0;
  int                  n_chk = 0;
  int                  n_fail = 0;
  int                  sq_cyc[$];
  logic [15:0]         sq_val[$];
  bit                  busy_at [4096];
  bit                  ovr_at  [4096];
  vec_t                vecs [7];
  int                  t, t2;

  fir_mac_accumulator #(
    .MAC_SIZE(MS), .MAC_NUM(MN), .SAMPLE_SIZE(SS),
    .COEFF_SIZE(CS), .OUT_SIZE(OS), .SHIFT(15)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .en_0_i(en_0), .en_1_i(en_1),
    .s_in_0_i(s_in_0), .s_in_1_i(s_in_1), .c_in_i(c_in),
    .y_out_o(y_out), .y_valid_o(y_valid), .busy_o(busy), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Mid-cycle record of strobes and status per cycle
  always @(negedge clk) begin
    if (cyc < 4096) begin
      busy_at[cyc] = busy;
      ovr_at[cyc]  = overrun;
    end
    if (y_valid) begin
      sq_cyc.push_back(cyc);
      sq_val.push_back(y_out);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start  = 1'b0;
    en_0   = 1'b0;
    en_1   = 1'b0;
    s_in_0 = '0;
    s_in_1 = '0;
    c_in   = '0;
  endtask

  task automatic clear_q();
    sq_cyc.delete();
    sq_val.delete();
  endtask

  // Assert start in the current cycle, then drive the taps over the next ncyc cycles
  task automatic pass(input vec_t v, input int ncyc);
    idle_in();
    start = 1'b1;
    en_0  = v.en0;
    en_1  = v.en1;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      idle_in();
      if (c <= int'(MS)) begin
        s_in_0 = (c == 1) ? v.s0_first : v.s0_rest;
        s_in_1 = v.s1;
        c_in   = v.c;
      end
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, {16'h0000, 16'h4000}, 32'h0, {16'h1234, 16'h5678}, {16'h2000, 16'h2000}, 16'h1000};
    vecs[1] = '{1'b1, 1'b1, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFF7FFF, 16'h7FFF};
    vecs[2] = '{1'b1, 1'b1, 32'h80008000, 32'h80008000, 32'h80008000, 32'h7FFF7FFF, 16'h8000};
    vecs[3] = '{1'b1, 1'b0, {16'h0000, 16'h0003}, 32'h0, 32'h0, 32'h40004000, 16'h0002};
    vecs[4] = '{1'b1, 1'b0, {16'h0000, 16'hFFFD}, 32'h0, 32'h0, 32'h40004000, 16'hFFFF};
    vecs[5] = '{1'b0, 1'b1, 32'h7FFF7FFF, 32'h7FFF7FFF, {16'd100, 16'd200}, {16'h0800, 16'h1000}, 16'h00FA};
    vecs[6] = '{1'b1, 1'b1, {16'd1000, 16'd1000}, {16'd1000, 16'd1000}, {16'hFC18, 16'd500}, {16'h4000, 16'h4000}, 16'h1770};

    idle_in();
    rst = 1'b1;
    repeat (3) tick();
    chk("reset y_out", 32'(y_out), 32'h0);
    chk("reset y_valid", 32'(y_valid), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    repeat (2) tick();

    // Single passes from the vector table
    for (int i = 0; i < 7; i++) begin
      clear_q();
      tick();
      t = cyc;
      pass(vecs[i], 16);
      chk($sformatf("vec%0d strobe_count", i), 32'(sq_cyc.size()), 32'd1);
      if (sq_cyc.size() > 0) begin
        chk($sformatf("vec%0d strobe_cycle", i), 32'(sq_cyc[0] - t), 32'd12);
        chk($sformatf("vec%0d y_out", i), 32'(sq_val[0]), 32'(vecs[i].exp_y));
      end
      chk($sformatf("vec%0d busy_t+1", i), 32'(busy_at[t+1]), 32'd1);
      chk($sformatf("vec%0d busy_t+12", i), 32'(busy_at[t+12]), 32'd1);
      chk($sformatf("vec%0d busy_t+13", i), 32'(busy_at[t+13]), 32'd0);
      chk($sformatf("vec%0d overrun", i), 32'(overrun), 32'd0);
    end

    // Start with both banks disabled is ignored
    begin
      vec_t vz;
      vz = vecs[1];
      vz.en0 = 1'b0;
      vz.en1 = 1'b0;
      clear_q();
      tick();
      t = cyc;
      pass(vz, 16);
      chk("nobank busy_t+1", 32'(busy_at[t+1]), 32'd0);
      chk("nobank strobe_count", 32'(sq_cyc.size()), 32'd0);
    end

    // Back-to-back: second start lands on the first pass's strobe cycle
    clear_q();
    tick();
    t = cyc;
    pass(vecs[6], 11);
    tick();
    pass(vecs[3], 16);
    chk("b2b strobe_count", 32'(sq_cyc.size()), 32'd2);
    if (sq_cyc.size() == 2) begin
      chk("b2b strobe0_cycle", 32'(sq_cyc[0] - t), 32'd12);
      chk("b2b strobe0_y", 32'(sq_val[0]), 32'h1770);
      chk("b2b strobe1_cycle", 32'(sq_cyc[1] - t), 32'd24);
      chk("b2b strobe1_y", 32'(sq_val[1]), 32'h0002);
    end
    chk("b2b busy_t+13", 32'(busy_at[t+13]), 32'd1);
    chk("b2b overrun", 32'(overrun), 32'd0);

    // Restart three cycles into a pass
    clear_q();
    tick();
    t = cyc;
    pass(vecs[1], 2);
    tick();
    t2 = cyc;
    pass(vecs[5], 16);
    chk("restart start_gap", 32'(t2 - t), 32'd3);
    chk("restart overrun_t+3", 32'(ovr_at[t+3]), 32'd0);
    chk("restart overrun_t+4", 32'(ovr_at[t+4]), 32'd1);
    chk("restart strobe_count", 32'(sq_cyc.size()), 32'd1);
    if (sq_cyc.size() > 0) begin
      chk("restart strobe_cycle", 32'(sq_cyc[0] - t), 32'd15);
      chk("restart y_out", 32'(sq_val[0]), 32'h00FA);
    end
    chk("restart overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-pass
    clear_q();
    tick();
    pass(vecs[0], 5);
    chk("midrst busy_before", 32'(busy), 32'd1);
    chk("midrst y_before", 32'(y_out), 32'h00FA);
    rst = 1'b1;
    #1;
    chk("midrst y_out", 32'(y_out), 32'h0);
    chk("midrst y_valid", 32'(y_valid), 32'h0);
    chk("midrst busy", 32'(busy), 32'h0);
    chk("midrst overrun", 32'(overrun), 32'h0);
    idle_in();
    repeat (2) tick();
    rst = 1'b0;
    repeat (15) tick();
    chk("midrst strobe_count", 32'(sq_cyc.size()), 32'd0);
    chk("midrst busy_after", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
